// File: rtl/sdio_bridge_pkg.sv
// Shared types and helpers for the SD-over-SPI slot multiplexer.
package sdio_bridge_pkg;

  // Bridge FSM: ACTIVE routes the selected slot, GUARD parks every slot.
  typedef enum logic [0:0] {
    StActive = 1'b0,
    StGuard  = 1'b1
  } bridge_state_e;

  // Legal parameter ranges.
  localparam int unsigned NumSlotsMin    = 1;
  localparam int unsigned NumSlotsMax    = 8;
  localparam int unsigned SyncStagesMin  = 2;
  localparam int unsigned SyncStagesMax  = 4;
  localparam int unsigned GuardCyclesMin = 1;
  localparam int unsigned GuardCyclesMax = 255;
  localparam int unsigned DebounceMin    = 2;
  localparam int unsigned DebounceMax    = 65535;

  // Width of a slot index; never narrower than one bit.
  function automatic int unsigned slot_idx_width(input int unsigned num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/sd_cd_debounce.sv
// Card-detect conditioning for one slot: 2-flop synchroniser, saturating
// stability counter, debounced presence and a one-cycle change pulse.
module sd_cd_debounce
  import sdio_bridge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic cd_n_i,
  output logic present_o,
  output logic change_o
);

  localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_q;
  logic [15:0] cnt_q;
  logic        present_q;
  logic        change_q;
  logic        differ;

  // present_q=1 stands for cd_n=0, so the raw level disagrees with the
  // current state exactly when it equals present_q.
  assign differ = (sync_q[1] == present_q);

  // Synchronise, count stable disagreement, toggle presence on expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser resets to the "no card" level so reset alone never
      // looks like an insertion.
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      present_q <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], cd_n_i};
      change_q <= 1'b0;
      if (!differ) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        present_q <= ~present_q;
        change_q  <= 1'b1;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign present_o = present_q;
  assign change_o  = change_q;

endmodule

// File: rtl/sdio_spi_mux_bridge.sv
// Routes one SPI controller to one of several SD card slots (SPI mode).
// Slot switches pass through a guard window in which every slot is parked.
module sdio_spi_mux_bridge
  import sdio_bridge_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned GUARD_CYCLES    = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  localparam int unsigned SW             = slot_idx_width(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_sck,
  input  logic [3:0]           spi_dq_o,
  input  logic                 spi_cs,
  output logic [3:0]           spi_dq_i,
  input  logic [SW-1:0]        slot_sel,
  input  logic                 slot_sel_valid,
  output logic                 slot_sel_ready,
  output logic                 slot_sel_err,
  output logic [SW-1:0]        active_slot,
  output logic [NUM_SLOTS-1:0] sd_sck,
  output logic [NUM_SLOTS-1:0] sd_cmd_o,
  output logic [NUM_SLOTS-1:0] sd_cmd_oe,
  output logic [NUM_SLOTS-1:0] sd_dat3_o,
  input  logic [NUM_SLOTS-1:0] sd_dat0_i,
  input  logic [NUM_SLOTS-1:0] sd_cd_n,
  output logic [NUM_SLOTS-1:0] card_present,
  output logic [NUM_SLOTS-1:0] card_change
);

  localparam int unsigned NumPad    = 2 ** SW;
  localparam logic [7:0]  GuardLoad = 8'(GUARD_CYCLES);

  bridge_state_e          state_q;
  logic [SW-1:0]          active_slot_q;
  logic [SW-1:0]          pend_slot_q;
  logic [7:0]             guard_q;
  logic                   err_q;
  logic [SYNC_STAGES-1:0] miso_q;
  logic [NumPad-1:0]      dat0_ext;
  logic [NUM_SLOTS-1:0]   route_en;
  logic                   req_in_range;
  logic                   unused_dq;

  // Only MOSI is forwarded; the other controller lanes are ignored.
  assign unused_dq = ^spi_dq_o[3:1];

  // Debounced card detect, one instance per slot.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_cd
    sd_cd_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cd (
      .clk      (clk),
      .reset    (reset),
      .cd_n_i   (sd_cd_n[g]),
      .present_o(card_present[g]),
      .change_o (card_change[g])
    );
  end

  assign req_in_range   = (32'(slot_sel) < NUM_SLOTS);
  assign slot_sel_ready = (state_q == StActive) && spi_cs;

  // Switch FSM: accept/reject requests, run the guard countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StActive;
      active_slot_q <= '0;
      pend_slot_q   <= '0;
      guard_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StActive: begin
          if (slot_sel_valid && slot_sel_ready) begin
            if (req_in_range) begin
              pend_slot_q <= slot_sel;
              guard_q     <= GuardLoad;
              state_q     <= StGuard;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StGuard: begin
          guard_q <= guard_q - 8'd1;
          if (guard_q == 8'd1) begin
            active_slot_q <= pend_slot_q;
            state_q       <= StActive;
          end
        end
        default: state_q <= StActive;
      endcase
    end
  end

  // Pad so the MISO mux index is always a full-width select.
  assign dat0_ext = NumPad'(sd_dat0_i);

  // MISO synchroniser; the mux follows active_slot even while parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      miso_q <= '0;
    end else begin
      miso_q <= {miso_q[SYNC_STAGES-2:0], dat0_ext[active_slot_q]};
    end
  end

  // A slot is routed only in ACTIVE, when selected and a card is present.
  always_comb begin
    route_en = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      route_en[i] = (state_q == StActive) && (active_slot_q == SW'(i)) && card_present[i];
    end
  end

  assign sd_sck       = route_en & {NUM_SLOTS{spi_sck}};
  assign sd_cmd_o     = ~route_en | {NUM_SLOTS{spi_dq_o[0]}};
  assign sd_cmd_oe    = route_en;
  assign sd_dat3_o    = ~route_en | {NUM_SLOTS{spi_cs}};
  assign spi_dq_i     = {2'b00, miso_q[SYNC_STAGES-1], 1'b0};
  assign slot_sel_err = err_q;
  assign active_slot  = active_slot_q;

endmodule

// File: tb/tb_sdio_spi_mux_bridge.sv
// Self-checking bench for sdio_spi_mux_bridge (2-slot main DUT, 3-slot DUT
// for out-of-range requests).
module tb_sdio_spi_mux_bridge;

  logic       clk;
  logic       reset;
  logic       spi_sck;
  logic [3:0] spi_dq_o;
  logic       spi_cs;
  logic [3:0] dq_in;
  logic [0:0] slot_sel;
  logic       slot_sel_valid;
  logic       slot_sel_ready;
  logic       slot_sel_err;
  logic [0:0] active_slot;
  logic [1:0] sd_sck, sd_cmd_o, sd_cmd_oe, sd_dat3_o, sd_dat0_i, sd_cd_n;
  logic [1:0] card_present, card_change;

  logic       spi_cs3;
  logic [3:0] dq_in3;
  logic [1:0] slot_sel3;
  logic       valid3, ready3, err3;
  logic [1:0] active3;
  logic [2:0] sck3, cmd3, oe3, dat3_3, present3, change3;

  int checks;
  int failures;
  logic [3:0] exp_q[$];

  sdio_spi_mux_bridge #(
    .NUM_SLOTS(2), .SYNC_STAGES(2), .GUARD_CYCLES(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_dq_o(spi_dq_o), .spi_cs(spi_cs),
    .spi_dq_i(dq_in), .slot_sel(slot_sel), .slot_sel_valid(slot_sel_valid),
    .slot_sel_ready(slot_sel_ready), .slot_sel_err(slot_sel_err), .active_slot(active_slot),
    .sd_sck(sd_sck), .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .sd_dat3_o(sd_dat3_o),
    .sd_dat0_i(sd_dat0_i), .sd_cd_n(sd_cd_n), .card_present(card_present),
    .card_change(card_change)
  );

  sdio_spi_mux_bridge #(
    .NUM_SLOTS(3), .SYNC_STAGES(2), .GUARD_CYCLES(4), .DEBOUNCE_CYCLES(8)
  ) dut3 (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_dq_o(spi_dq_o), .spi_cs(spi_cs3),
    .spi_dq_i(dq_in3), .slot_sel(slot_sel3), .slot_sel_valid(valid3),
    .slot_sel_ready(ready3), .slot_sel_err(err3), .active_slot(active3),
    .sd_sck(sck3), .sd_cmd_o(cmd3), .sd_cmd_oe(oe3), .sd_dat3_o(dat3_3),
    .sd_dat0_i(3'b000), .sd_cd_n(3'b111), .card_present(present3),
    .card_change(change3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_sck = 1'b0; spi_dq_o = 4'h0; spi_cs = 1'b1; slot_sel = 1'b0;
    slot_sel_valid = 1'b0; sd_dat0_i = 2'b00; sd_cd_n = 2'b11;
    spi_cs3 = 1'b1; slot_sel3 = 2'd0; valid3 = 1'b0;
    step(3);
    reset = 1'b0;
    #1;
    checks++;
    if ({active_slot, card_present, card_change, slot_sel_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_state: got %b want 000000",
               {active_slot, card_present, card_change, slot_sel_err});
    end
    checks++;
    if ({sd_sck, sd_cmd_o, sd_cmd_oe, sd_dat3_o} !== 8'b00_11_00_11) begin
      failures++;
      $display("FAIL reset_parked: got %b want 00110011", {sd_sck, sd_cmd_o, sd_cmd_oe, sd_dat3_o});
    end
    checks++;
    if ({slot_sel_ready, dq_in} !== 5'b1_0000) begin
      failures++;
      $display("FAIL reset_ready_miso: got %b want 10000", {slot_sel_ready, dq_in});
    end
  endtask

  task automatic test_card_detect();
    int n;
    bit bad;
    sd_cd_n = 2'b00;
    n = 0;
    while (card_present[0] !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL cd_latency: got %0d cycles want 10", n);
    end
    checks++;
    if ({card_present, card_change} !== 4'b11_11) begin
      failures++;
      $display("FAIL cd_rise: got %b want 1111", {card_present, card_change});
    end
    step(1);
    checks++;
    if (card_change !== 2'b00) begin
      failures++;
      $display("FAIL cd_pulse_width: got %b want 00", card_change);
    end
    sd_cd_n[0] = 1'b1;
    step(3);
    sd_cd_n[0] = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (card_change !== 2'b00 || card_present !== 2'b11) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL cd_glitch: got change/present disturbed want stable 11");
    end
  endtask

  task automatic test_routing();
    logic e_sck, e_mosi;
    spi_cs = 1'b0;
    #1;
    checks++;
    if ({slot_sel_ready, sd_dat3_o} !== 3'b0_10) begin
      failures++;
      $display("FAIL route_cs: got %b want 010", {slot_sel_ready, sd_dat3_o});
    end
    for (int i = 0; i < 4; i++) begin
      e_sck  = i[1];
      e_mosi = i[0];
      spi_sck = e_sck;
      spi_dq_o = {3'b101, e_mosi};
      #1;
      checks++;
      if ({sd_sck, sd_cmd_o, sd_cmd_oe, sd_dat3_o} !== {1'b0, e_sck, 1'b1, e_mosi, 2'b01, 2'b10})
      begin
        failures++;
        $display("FAIL route_pattern%0d: got %b want %b", i,
                 {sd_sck, sd_cmd_o, sd_cmd_oe, sd_dat3_o},
                 {1'b0, e_sck, 1'b1, e_mosi, 2'b01, 2'b10});
      end
      step(1);
    end
    spi_sck = 1'b0;
    spi_dq_o = 4'h0;
    spi_cs = 1'b1;
  endtask

  task automatic test_miso();
    logic b;
    logic [3:0] exp_v;
    for (int i = 0; i < 16; i++) begin
      if (exp_q.size() == 2) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (dq_in !== exp_v) begin
          failures++;
          $display("FAIL miso_%0d: got %b want %b", i, dq_in, exp_v);
        end
      end
      b = (i < 2) ? 1'b0 : (i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      sd_dat0_i = {~b, b};
      exp_q.push_back({2'b00, b, 1'b0});
      step(1);
    end
    while (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (dq_in !== exp_v) begin
        failures++;
        $display("FAIL miso_drain: got %b want %b", dq_in, exp_v);
      end
      step(1);
    end
  endtask

  task automatic test_switch();
    spi_cs = 1'b0;
    slot_sel = 1'b1;
    slot_sel_valid = 1'b1;
    #1;
    checks++;
    if (slot_sel_ready !== 1'b0) begin
      failures++;
      $display("FAIL sw_busy_ready: got %b want 0", slot_sel_ready);
    end
    step(1);
    checks++;
    if ({active_slot, sd_cmd_oe} !== 3'b0_01) begin
      failures++;
      $display("FAIL sw_busy_noswitch: got %b want 001", {active_slot, sd_cmd_oe});
    end
    spi_cs = 1'b1;
    #1;
    checks++;
    if (slot_sel_ready !== 1'b1) begin
      failures++;
      $display("FAIL sw_idle_ready: got %b want 1", slot_sel_ready);
    end
    step(1);
    slot_sel_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) spi_cs = 1'b0;
      #1;
      checks++;
      if ({slot_sel_ready, sd_sck, sd_cmd_oe, sd_dat3_o, active_slot} !== 8'b0_00_00_11_0) begin
        failures++;
        $display("FAIL sw_guard%0d: got %b want 00000110", i,
                 {slot_sel_ready, sd_sck, sd_cmd_oe, sd_dat3_o, active_slot});
      end
      step(1);
    end
    spi_sck = 1'b1;
    #1;
    checks++;
    if ({active_slot, sd_cmd_oe, sd_dat3_o, sd_sck} !== 7'b1_10_01_10) begin
      failures++;
      $display("FAIL sw_routed1: got %b want 1100110", {active_slot, sd_cmd_oe, sd_dat3_o, sd_sck});
    end
    spi_sck = 1'b0;
  endtask

  task automatic test_removal();
    int n;
    sd_cd_n[1] = 1'b1;
    step(9);
    checks++;
    if (sd_cmd_oe !== 2'b10) begin
      failures++;
      $display("FAIL rm_early: got %b want 10", sd_cmd_oe);
    end
    step(1);
    checks++;
    if ({sd_cmd_oe, sd_dat3_o, card_change} !== 6'b00_11_10) begin
      failures++;
      $display("FAIL rm_parked: got %b want 001110", {sd_cmd_oe, sd_dat3_o, card_change});
    end
    sd_cd_n[1] = 1'b0;
    n = 0;
    while (card_present[1] !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    checks++;
    if ({n == 10, sd_cmd_oe, sd_dat3_o} !== 5'b1_10_01) begin
      failures++;
      $display("FAIL rm_resume: got n=%0d oe=%b dat3=%b want n=10 oe=10 dat3=01",
               n, sd_cmd_oe, sd_dat3_o);
    end
    spi_cs = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [0:0] tgt;
    for (int k = 0; k < 2; k++) begin
      tgt = (k == 0) ? 1'b1 : 1'b0;
      slot_sel = tgt;
      slot_sel_valid = 1'b1;
      step(1);
      slot_sel_valid = 1'b0;
      n = 0;
      while (sd_cmd_oe === 2'b00 && n < 20) begin
        n++;
        step(1);
      end
      checks++;
      if (n != 4 || active_slot !== tgt || slot_sel_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d: got n=%0d slot=%b ready=%b want n=4 slot=%b ready=1",
                 k, n, active_slot, slot_sel_ready, tgt);
      end
    end
  endtask

  task automatic test_err();
    slot_sel3 = 2'd3;
    valid3 = 1'b1;
    step(1);
    valid3 = 1'b0;
    checks++;
    if ({err3, active3, ready3} !== 4'b1_00_1) begin
      failures++;
      $display("FAIL err_pulse: got %b want 1001", {err3, active3, ready3});
    end
    step(1);
    checks++;
    if ({err3, active3} !== 3'b0_00) begin
      failures++;
      $display("FAIL err_once: got %b want 000", {err3, active3});
    end
    slot_sel3 = 2'd2;
    valid3 = 1'b1;
    step(1);
    valid3 = 1'b0;
    step(4);
    checks++;
    if ({err3, active3, oe3} !== 6'b0_10_000) begin
      failures++;
      $display("FAIL err_inrange: got %b want 010000", {err3, active3, oe3});
    end
  endtask

  task automatic test_reset_in_guard();
    slot_sel = 1'b1;
    slot_sel_valid = 1'b1;
    step(2);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    slot_sel_valid = 1'b0;
    #1;
    checks++;
    if ({active_slot, slot_sel_ready, card_present, sd_cmd_oe} !== 6'b0_1_00_00) begin
      failures++;
      $display("FAIL rst_guard: got %b want 010000",
               {active_slot, slot_sel_ready, card_present, sd_cmd_oe});
    end
    step(6);
    checks++;
    if ({active_slot, slot_sel_ready} !== 2'b0_1) begin
      failures++;
      $display("FAIL rst_abandon: got %b want 01", {active_slot, slot_sel_ready});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_card_detect();
    test_routing();
    test_miso();
    test_switch();
    test_removal();
    test_back_to_back();
    test_err();
    test_reset_in_guard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdio_spi_mux_bridge.md
SDIO_SPI_MUX_BRIDGE -- requirements
Module: sdio_spi_mux_bridge

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 2: number of SD card slots, range 1..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: MISO synchroniser depth, range 2..4.
REQ-003 SHALL have parameter GUARD_CYCLES, default 4: clk cycles all slots are idle between slot switches, range 1..255.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1000: card-detect stable time in clk cycles, range 2..65535.
REQ-005 SHALL have these ports; SW is clog2(NUM_SLOTS), minimum 1:
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-high.
- spi_sck  in  1  SPI clock from the controller.
- spi_dq_o  in  4  controller data out; bit 0 is MOSI.
- spi_cs  in  1  controller chip select, active-low.
- spi_dq_i  out  4  controller data in: {2'b00, MISO, 1'b0}.
- slot_sel  in  SW  requested slot index.
- slot_sel_valid  in  1  slot-switch request.
- slot_sel_ready  out  1  bridge can accept a switch.
- slot_sel_err  out  1  one-cycle pulse: request rejected.
- active_slot  out  SW  currently routed slot.
- sd_sck  out  NUM_SLOTS  per-slot card clock.
- sd_cmd_o  out  NUM_SLOTS  per-slot CMD (MOSI) drive value.
- sd_cmd_oe  out  NUM_SLOTS  per-slot CMD output enable.
- sd_dat3_o  out  NUM_SLOTS  per-slot DAT3 (CS) drive value; always enabled.
- sd_dat0_i  in  NUM_SLOTS  per-slot DAT0 (MISO).
- sd_cd_n  in  NUM_SLOTS  per-slot raw card detect, active-low, asynchronous.
- card_present  out  NUM_SLOTS  debounced presence.
- card_change  out  NUM_SLOTS  one-cycle pulse on any card_present edge.

Function
REQ-006 SHALL implement an FSM with two states: ACTIVE and GUARD.
REQ-007 In ACTIVE, the slot s = active_slot with card_present[s]=1 SHALL be routed:
- sd_sck[s]=spi_sck, sd_cmd_o[s]=spi_dq_o[0], sd_cmd_oe[s]=1, sd_dat3_o[s]=spi_cs.
REQ-008 Every non-routed slot, and every slot while in GUARD, SHALL be parked: sd_sck=0, sd_cmd_o=1, sd_cmd_oe=0, sd_dat3_o=1.
REQ-009 A routed slot whose card_present falls SHALL be parked from the next cycle; routing SHALL resume when presence returns.
REQ-010 slot_sel_ready SHALL be 1 only in ACTIVE with spi_cs=1 (controller idle).
REQ-011 On slot_sel_valid & slot_sel_ready with slot_sel<NUM_SLOTS, the bridge SHALL latch slot_sel, load the guard counter with GUARD_CYCLES, and enter GUARD.
REQ-012 On slot_sel_valid & slot_sel_ready with slot_sel>=NUM_SLOTS, the bridge SHALL pulse slot_sel_err for one cycle and remain in ACTIVE with active_slot unchanged.
REQ-013 A request equal to the current active_slot SHALL still pass through GUARD.
REQ-014 In GUARD, the counter SHALL decrement each cycle; at count 1 the FSM SHALL enter ACTIVE with active_slot updated, so all slots are parked for exactly GUARD_CYCLES cycles.
REQ-015 spi_cs falling during GUARD SHALL be ignored; no slot is selected until ACTIVE.
REQ-016 MISO path: sd_dat0_i[active_slot] SHALL pass through SYNC_STAGES flops.
- The last stage drives spi_dq_i[1].
- Latency is SYNC_STAGES clk cycles.
- The input mux selects sd_dat0_i[active_slot] in all states; a parked slot's input is not forced.
REQ-017 spi_dq_i[3:2] and spi_dq_i[0] SHALL be constant 0.
REQ-018 Each sd_cd_n bit SHALL pass through a 2-flop synchroniser and then a saturating counter.
- The counter clears whenever the synchronised value equals the current state.
- card_present toggles when the counter reaches DEBOUNCE_CYCLES-1 with the value still differing.
- card_change pulses in the same cycle card_present updates.
REQ-019 card_present = 1 SHALL mean synchronised sd_cd_n = 0.

Reset
REQ-020 reset SHALL act on the clk edge and take priority over all other events, including a request accepted in the same cycle.
REQ-021 During and after reset:
- state=ACTIVE, active_slot=0, guard counter=0.
- All MISO sync flops=0; all debounce counters=0; card_present=0; card_change=0; slot_sel_err=0.
- As a result, all slots are parked until a card is debounced present.
REQ-022 Reset asserted in GUARD SHALL abandon the pending switch.

Structure
REQ-023 Package sdio_bridge_pkg SHALL hold the FSM state enum, the slot-index width function, and parameter range constants.
REQ-024 Sub-module sd_cd_debounce (synchroniser, counter, present/change) SHALL be instantiated once per slot via generate.

Verification
REQ-025 Defaults (NUM_SLOTS=2, SYNC_STAGES=2, GUARD_CYCLES=4, DEBOUNCE_CYCLES=8) SHALL be used unless stated.
REQ-026 Scenario: sd_cd_n[0]=0 held 10 cycles after reset -> card_present[0] rises with a 1-cycle card_change[0]; a 3-cycle glitch to 1 causes no change.
REQ-027 Scenario: slot 0 present, spi_cs=0, toggle spi_sck and MOSI -> sd_sck[0]/sd_cmd_o[0] follow and sd_dat3_o[0]=0; slot 1 stays parked.
REQ-028 Scenario: sd_dat0_i[0] 0->1 -> spi_dq_i=4'b0010 exactly 2 cycles later.
REQ-029 Scenario: spi_cs=1, slot_sel=1 with valid -> ready drops, both slots parked 4 cycles, then active_slot=1 and slot 1 routed; valid with spi_cs=0 -> ready=0 and no switch.
REQ-030 Scenario: NUM_SLOTS=3, slot_sel=3 -> slot_sel_err pulses once, active_slot unchanged.
REQ-031 Scenario: remove the active card mid-transfer -> 8 cycles after the synchronised edge, the slot is parked with sd_dat3_o=1; reset in GUARD -> active_slot=0.
